// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: register scoreboard and issue/drain controller for decode; WB_BYPASS_EN enables writeback-to-decode forwarding
module decode_hazard_ctrl #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 3,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic                   id_use1,
  input  logic [ADDR_W-1:0]      id_rsrc1,
  input  logic                   id_use2,
  input  logic [ADDR_W-1:0]      id_rsrc2,
  input  logic                   id_wr,
  input  logic [ADDR_W-1:0]      id_rdst,
  input  logic                   ex_ready,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_rdst,
  input  logic                   drain_req,
  output logic                   stall,
  output logic                   issue,
  output logic                   drain_ack,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   sb_err
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;
  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_pend [NUM_REGS];
  logic [CNT_W-1:0]      w_pend_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]   w_inc, w_dec, w_busy_nxt;
  logic                  w_fwd1, w_fwd2, w_raw, w_sat, w_block, w_wb_err, w_all_zero;
  logic                  r_drain_ack, r_sb_err;
  logic [NUM_REGS-1:0]   r_busy_mask;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
`ifdef WB_BYPASS_EN
  assign w_fwd1 = wb_valid && wb_rdst == id_rsrc1 && r_pend[id_rsrc1] == ONE;
  assign w_fwd2 = wb_valid && wb_rdst == id_rsrc2 && r_pend[id_rsrc2] == ONE;
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif
  // Hazards look at pre-update counts; drain_req blocks in its own request cycle
  assign w_raw   = (id_use1 && r_pend[id_rsrc1] != '0 && !w_fwd1) ||
                   (id_use2 && r_pend[id_rsrc2] != '0 && !w_fwd2);
  assign w_sat   = id_wr && r_pend[id_rdst] == '1;
  assign w_block = w_raw || w_sat || !ex_ready || r_state != RUN || drain_req;
  assign issue   = id_valid && !flush && !w_block;
  assign stall   = id_valid && !flush && w_block;
  assign w_inc   = (issue && id_wr) ? NUM_REGS'(1) << id_rdst : '0;
  assign w_dec   = wb_valid ? NUM_REGS'(1) << wb_rdst : '0;
  // A retire into an empty counter is an error unless an issue to the same register cancels it
  assign w_wb_err   = wb_valid && r_pend[wb_rdst] == '0 && !w_inc[wb_rdst];
  assign w_all_zero = w_busy_nxt == '0;
  // Per-register next count: paired inc/dec cancel, decrement floors at zero
  always_comb begin
    w_busy_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pend_nxt[i] = (w_inc[i] == w_dec[i]) ? r_pend[i] :
                      w_inc[i] ? r_pend[i] + ONE :
                      (r_pend[i] == '0) ? r_pend[i] : r_pend[i] - ONE;
      w_busy_nxt[i] = w_pend_nxt[i] != '0;
    end
  end
  // Drain FSM next state; completion is judged on post-update counts
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     w_state_nxt = drain_req ? DRAIN : RUN;
      DRAIN:   w_state_nxt = !drain_req ? RUN : (w_all_zero ? DRAINED : DRAIN);
      DRAINED: w_state_nxt = drain_req ? DRAINED : RUN;
      default: w_state_nxt = RUN;
    endcase
  end
  // Drain FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_nxt;
  end
  // Pending-write counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    else      r_pend <= w_pend_nxt;
  end
  // Registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drain_ack <= 1'b0;
      r_busy_mask <= '0;
      r_stall_cnt <= '0;
      r_sb_err    <= 1'b0;
    end else begin
      r_drain_ack <= w_state_nxt == DRAINED;
      r_busy_mask <= w_busy_nxt;
      r_stall_cnt <= (stall && r_stall_cnt != '1) ? r_stall_cnt + STALL_CNT_W'(1) : r_stall_cnt;
      r_sb_err    <= r_sb_err || w_wb_err;
    end
  end
  assign drain_ack = r_drain_ack;
  assign busy_mask = r_busy_mask;
  assign stall_cnt = r_stall_cnt;
  assign sb_err    = r_sb_err;
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl: directed vector table plus randomized traffic against a scoreboard model
module tb_decode_hazard_ctrl;
`ifdef WB_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid, id_use1, id_use2, id_wr, ex_ready, flush, wb_valid, drain_req;
  logic [2:0] id_rsrc1, id_rsrc2, id_rdst, wb_rdst;
  logic stall, issue, drain_ack, sb_err;
  logic [7:0] busy_mask;
  logic [15:0] stall_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  decode_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_use1(id_use1), .id_rsrc1(id_rsrc1),
    .id_use2(id_use2), .id_rsrc2(id_rsrc2), .id_wr(id_wr), .id_rdst(id_rdst),
    .ex_ready(ex_ready), .flush(flush), .wb_valid(wb_valid), .wb_rdst(wb_rdst),
    .drain_req(drain_req), .stall(stall), .issue(issue), .drain_ack(drain_ack),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt), .sb_err(sb_err)
  );
  typedef struct {
    bit v, u1; int s1; bit u2; int s2; bit wr; int d; bit rdy, fl, wbv; int wbd; bit dr;
    bit es, ei; int eb; bit ea, ee;
  } vec_t;
  vec_t tv[$];
  int pend[8];
  int mode;
  int sc;
  bit err;
  bit dr_lvl;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic void add(input bit v, u1, input int s1, input bit u2, input int s2,
                              input bit wr, input int d, input bit rdy, fl, wbv, input int wbd,
                              input bit dr, input bit es, ei, input int eb, input bit ea, ee);
    vec_t t;
    t.v = v; t.u1 = u1; t.s1 = s1; t.u2 = u2; t.s2 = s2; t.wr = wr; t.d = d;
    t.rdy = rdy; t.fl = fl; t.wbv = wbv; t.wbd = wbd; t.dr = dr;
    t.es = es; t.ei = ei; t.eb = eb; t.ea = ea; t.ee = ee;
    tv.push_back(t);
  endfunction
  task automatic drive(input vec_t t);
    id_valid = t.v; id_use1 = t.u1; id_rsrc1 = 3'(t.s1); id_use2 = t.u2; id_rsrc2 = 3'(t.s2);
    id_wr = t.wr; id_rdst = 3'(t.d); ex_ready = t.rdy; flush = t.fl;
    wb_valid = t.wbv; wb_rdst = 3'(t.wbd); drain_req = t.dr;
  endtask
  task automatic idle();
    vec_t t;
    t = '{default: 0};
    drive(t);
  endtask
  function automatic vec_t rnd();
    vec_t t;
    t = '{default: 0};
    t.v = $urandom_range(3) != 0; t.u1 = $urandom_range(1) == 1; t.s1 = $urandom_range(7);
    t.u2 = $urandom_range(1) == 1; t.s2 = $urandom_range(7); t.wr = $urandom_range(3) != 0;
    t.d = $urandom_range(7); t.rdy = $urandom_range(4) != 0; t.fl = $urandom_range(9) == 0;
    t.wbv = $urandom_range(1) == 1; t.wbd = $urandom_range(7);
    if (pend[t.wbd] == 0 && $urandom_range(7) != 0)
      for (int i = 0; i < 8; i++) if (pend[i] > 0) t.wbd = i;
    if ($urandom_range(19) == 0) dr_lvl = !dr_lvl;
    t.dr = dr_lvl;
    return t;
  endfunction
  function automatic void model_comb(input vec_t t, output bit es, output bit ei);
    bit h1, h2, sat, blk;
    h1 = t.u1 && pend[t.s1] > 0 && !(BP && t.wbv && t.wbd == t.s1 && pend[t.s1] == 1);
    h2 = t.u2 && pend[t.s2] > 0 && !(BP && t.wbv && t.wbd == t.s2 && pend[t.s2] == 1);
    sat = t.wr && pend[t.d] == 3;
    blk = h1 || h2 || sat || !t.rdy || mode != 0 || t.dr;
    ei = t.v && !t.fl && !blk;
    es = t.v && !t.fl && blk;
  endfunction
  function automatic void model_update(input vec_t t, input bit es, input bit ei);
    bit allz;
    if (!(ei && t.wr && t.wbv && t.d == t.wbd)) begin
      if (ei && t.wr) pend[t.d]++;
      if (t.wbv) begin
        if (pend[t.wbd] == 0) err = 1'b1;
        else pend[t.wbd]--;
      end
    end
    if (es && sc < 65535) sc++;
    allz = 1'b1;
    for (int i = 0; i < 8; i++) if (pend[i] != 0) allz = 1'b0;
    if (mode == 0)      mode = t.dr ? 1 : 0;
    else if (mode == 1) mode = !t.dr ? 0 : (allz ? 2 : 1);
    else                mode = t.dr ? 2 : 0;
  endfunction
  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < 8; i++) if (pend[i] > 0) m |= (1 << i);
    return m;
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < 8; i++) pend[i] = 0;
    mode = 0; sc = 0; err = 1'b0; dr_lvl = 1'b0;
  endfunction
  initial begin
    vec_t t;
    bit es, ei;
    int exp_sc;
    //   v u1 s1 u2 s2 wr d rdy fl wbv wbd dr | stall issue busy ack err
    add(1, 1, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0,  0, 1, 8'h02, 0, 0);
    add(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0,  0, 1, 8'h0A, 0, 0);
    add(1, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0,  1, 0, 8'h0A, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0, 1, 0, 1, 3, 0,  !BP, BP, 8'h02, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 8'h02, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 8'h02, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0,  0, 1, 8'h22, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0,  0, 1, 8'h22, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0,  0, 1, 8'h22, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0,  1, 0, 8'h22, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 0,  0, 0, 8'h22, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 5, 0,  0, 1, 8'h22, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0,  0, 1, 8'h22, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0,  1, 0, 8'h22, 0, 0);
    add(1, 1, 5, 0, 0, 1, 5, 1, 1, 0, 0, 0,  0, 0, 8'h22, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6, 0,  0, 0, 8'h22, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 8'h22, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1,  1, 0, 8'h22, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 1, 0, 1, 1, 1,  1, 0, 8'h20, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 1,  0, 0, 8'h20, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 1,  0, 0, 8'h20, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 1,  0, 0, 8'h00, 1, 1);
    add(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1,  1, 0, 8'h00, 1, 1);
    add(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0,  1, 0, 8'h00, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0,  0, 1, 8'h04, 0, 1);
    idle();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", int'(busy_mask), 0);
    chk("rst_ack", int'(drain_ack), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    chk("rst_err", int'(sb_err), 0);
    exp_sc = 0;
    foreach (tv[k]) begin
      drive(tv[k]);
      #4;
      chk($sformatf("v%0d_stall", k), int'(stall), int'(tv[k].es));
      chk($sformatf("v%0d_issue", k), int'(issue), int'(tv[k].ei));
      @(posedge clk); #1;
      if (tv[k].es) exp_sc++;
      chk($sformatf("v%0d_busy", k), int'(busy_mask), tv[k].eb);
      chk($sformatf("v%0d_ack", k), int'(drain_ack), int'(tv[k].ea));
      chk($sformatf("v%0d_err", k), int'(sb_err), int'(tv[k].ee));
      chk($sformatf("v%0d_cnt", k), int'(stall_cnt), exp_sc);
    end
    model_reset();
    t = rnd();
    drive(t);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", int'(busy_mask), 0);
    chk("arst_err", int'(sb_err), 0);
    chk("arst_cnt", int'(stall_cnt), 0);
    idle();
    #4 rst = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 600; n++) begin
      t = rnd();
      drive(t);
      model_comb(t, es, ei);
      #4;
      chk("rnd_stall", int'(stall), int'(es));
      chk("rnd_issue", int'(issue), int'(ei));
      @(posedge clk); #1;
      model_update(t, es, ei);
      chk("rnd_busy", int'(busy_mask), model_mask());
      chk("rnd_ack", int'(drain_ack), int'(mode == 2));
      chk("rnd_cnt", int'(stall_cnt), sc);
      chk("rnd_err", int'(sb_err), int'(err));
    end
    t = rnd();
    drive(t);
    #1 rst = 1'b0;
    #1;
    chk("arst2_busy", int'(busy_mask), 0);
    chk("arst2_ack", int'(drain_ack), 0);
    chk("arst2_cnt", int'(stall_cnt), 0);
    chk("arst2_err", int'(sb_err), 0);
    idle();
    #4 rst = 1'b1;
    @(posedge clk); #1;
    t = '{default: 0};
    t.v = 1; t.u1 = 1; t.s1 = 2; t.wr = 1; t.d = 1; t.rdy = 1;
    drive(t);
    #4;
    chk("post_issue", int'(issue), 1);
    chk("post_stall", int'(stall), 0);
    @(posedge clk); #1;
    chk("post_busy", int'(busy_mask), 8'h02);
    idle();
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
